// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// Handshake: start is sampled only while busy=0 and captures a/b/bin on that edge; busy stays high
// until the operation retires, and done pulses for one cycle when diff/bout/ovf have just been updated.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin over WIDTH cycles, LSB first.
// Results, borrow-out and overflow are held in registers until the next operation retires.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_subtractor_if.slave   bus,
  output logic [1:0]           dbg_state
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             borrow_q, borrow_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             x_bit, y_bit, d_bit, borrow_nxt;
  logic [WIDTH-1:0] res_nxt;

  always_comb begin
    x_bit      = a_sh_q[0];
    y_bit      = b_sh_q[0];
    d_bit      = x_bit ^ y_bit ^ borrow_q;
    borrow_nxt = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow_q);
    res_nxt    = {d_bit, res_q[WIDTH-1:1]};

    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_d    = res_q;
    diff_d   = diff_q;
    cnt_d    = cnt_q;
    borrow_d = borrow_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d  = S_SHIFT;
          a_sh_d   = bus.a;
          b_sh_d   = bus.b;
          borrow_d = bus.bin;
          cnt_d    = '0;
          a_msb_d  = bus.a[WIDTH-1];
          b_msb_d  = bus.b[WIDTH-1];
        end
      end
      S_SHIFT: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_d    = res_nxt;
        borrow_d = borrow_nxt;
        if (cnt_q == CW'(WIDTH - 1)) begin
          // Last bit: d_bit is the result MSB, so overflow is decided here.
          state_d = S_DONE;
          diff_d  = res_nxt;
          bout_d  = borrow_nxt;
          ovf_d   = (a_msb_q ^ b_msb_q) & (d_bit ^ a_msb_q);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_q    <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_q    <= res_d;
      diff_q   <= diff_d;
      cnt_q    <= cnt_d;
      borrow_q <= borrow_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.diff  = diff_q;
  assign bus.bout  = bout_q;
  assign bus.ovf   = ovf_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized bench for serial_subtractor (WIDTH=4) against an arithmetic reference model.
module tb_serial_subtractor;
  localparam int W  = 4;
  localparam int MW = W + 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  serial_subtractor_if #(.WIDTH(W)) bus();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [MW-1:0] exp_q[$];   // {bout, ovf, diff}
  logic [MW-1:0] held;       // outputs the DUT should currently be holding

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] outs();
    return {bus.bout, bus.ovf, bus.diff};
  endfunction

  // Reference: plain integer arithmetic, unsigned for borrow, signed range for overflow.
  function automatic logic [MW-1:0] ref_sub(input int av, input int bv, input int bn);
    int dv, sa, sb, sd;
    logic [W-1:0] dd;
    logic bo, ov;
    dv = av - bv - bn;
    dd = dv[W-1:0];
    bo = (av < bv + bn);
    sa = (av >= 2**(W-1)) ? av - 2**W : av;
    sb = (bv >= 2**(W-1)) ? bv - 2**W : bv;
    sd = sa - sb - bn;
    ov = (sd > 2**(W-1) - 1) || (sd < -(2**(W-1)));
    return {bo, ov, dd};
  endfunction

  task automatic retire(input string tag);
    chk({tag, ":sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      held = exp_q.pop_front();
      chk({tag, ":result"}, 32'(outs()), 32'(held));
    end
  endtask

  // ---------------- driver tasks ----------------
  // One operation from IDLE; disturb=1 pulses start and scrambles operands during SHIFT and DONE.
  task automatic run_op(input int av, input int bv, input int bn, input bit disturb, input string tag);
    @(negedge clk);
    bus.a = W'(av); bus.b = W'(bv); bus.bin = bn[0]; bus.start = 1'b1;
    exp_q.push_back(ref_sub(av, bv, bn));
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ":busy_e0"}, 32'(bus.busy), 32'd1);
    for (int k = 1; k <= W; k++) begin
      if (disturb && k == 1) begin
        bus.a = W'($urandom_range(0, 2**W - 1));
        bus.b = W'($urandom_range(0, 2**W - 1));
        bus.bin = 1'($urandom_range(0, 1));
        bus.start = 1'b1;
      end
      if (disturb && k == 2) bus.start = 1'b0;
      @(posedge clk); #1;
      if (k < W) begin
        chk({tag, ":done_early"}, 32'(bus.done), 32'd0);
        chk({tag, ":busy_shift"}, 32'(bus.busy), 32'd1);
        chk({tag, ":hold_shift"}, 32'(outs()), 32'(held));
      end else begin
        chk({tag, ":done"}, 32'(bus.done), 32'd1);
        chk({tag, ":busy_done"}, 32'(bus.busy), 32'd1);
        retire(tag);
      end
    end
    if (disturb) begin
      bus.a = W'($urandom_range(0, 2**W - 1));
      bus.start = 1'b1;
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk({tag, ":done_fall"}, 32'(bus.done), 32'd0);
    chk({tag, ":busy_fall"}, 32'(bus.busy), 32'd0);
    chk({tag, ":hold_idle"}, 32'(outs()), 32'(held));
  endtask

  // start held high for n operations; each should be accepted 6 cycles after the previous one.
  task automatic run_b2b(input int n);
    int av[8], bv[8], bn[8];
    for (int i = 0; i < 8; i++) begin
      av[i] = $urandom_range(0, 2**W - 1);
      bv[i] = $urandom_range(0, 2**W - 1);
      bn[i] = $urandom_range(0, 1);
    end
    @(negedge clk);
    bus.a = W'(av[0]); bus.b = W'(bv[0]); bus.bin = bn[0][0]; bus.start = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(ref_sub(av[i], bv[i], bn[i]));
      @(posedge clk); #1;
      chk("b2b:busy_accept", 32'(bus.busy), 32'd1);
      if (i + 1 < n) begin
        bus.a = W'(av[i+1]); bus.b = W'(bv[i+1]); bus.bin = bn[i+1][0];
      end else begin
        bus.start = 1'b0;
      end
      for (int k = 1; k <= W; k++) begin
        @(posedge clk); #1;
        if (k < W) chk("b2b:done_early", 32'(bus.done), 32'd0);
        else begin
          chk("b2b:done", 32'(bus.done), 32'd1);
          retire("b2b");
        end
      end
      @(posedge clk); #1;
      chk("b2b:busy_idle", 32'(bus.busy), 32'd0);
      chk("b2b:done_idle", 32'(bus.done), 32'd0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ":busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ":done"}, 32'(bus.done), 32'd0);
    chk({tag, ":outs"}, 32'(outs()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0;
    held = '0;
    #12;
    chk_all_zero("reset_init");
    @(negedge clk); rst_n = 1'b1;

    run_op(4'b0101, 4'b0010, 0, 1'b0, "basic");
    chk("basic:value", 32'(held), 32'(6'b00_0011));

    // Asynchronous reset between edges clears outputs at once.
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_async");
    @(negedge clk); rst_n = 1'b1; held = '0;

    run_op(4'b0000, 4'b0001, 0, 1'b0, "borrow");
    chk("borrow:value", 32'(held), 32'(6'b10_1111));
    run_op(4'b1000, 4'b0001, 0, 1'b0, "ovf_pos");
    chk("ovf_pos:value", 32'(held), 32'(6'b01_0111));
    run_op(4'b0111, 4'b1111, 0, 1'b0, "ovf_neg");
    chk("ovf_neg:value", 32'(held), 32'(6'b11_1000));
    run_op(4'b1111, 4'b1111, 1, 1'b0, "bin_ones");
    chk("bin_ones:value", 32'(held), 32'(6'b10_1111));
    run_op(4'b0000, 4'b0000, 1, 1'b0, "bin_zero");
    chk("bin_zero:value", 32'(held), 32'(6'b10_1111));

    for (int i = 0; i < 3; i++)
      run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 1'b1, "disturb");

    // Reset after E2 aborts the operation with no done pulse.
    @(negedge clk);
    bus.a = 4'b1010; bus.b = 4'b0101; bus.bin = 1'b0; bus.start = 1'b1;
    @(posedge clk); #1; bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("reset_midop");
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("reset_midop:no_done", 32'(bus.done), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; held = '0;
    run_op(4'b1010, 4'b0101, 0, 1'b0, "after_reset");
    chk("after_reset:value", 32'(held), 32'(6'b01_0101));

    for (int i = 0; i < 20; i++)
      run_op($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 1), 1'b0, "random");

    run_b2b(4);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Multi-cycle bit-serial subtractor computing `diff = a - b - bin` over WIDTH clock cycles, one bit per cycle, LSB first. It is the subtraction counterpart to the team's 4-bit carry-look-ahead adder and serves area-constrained datapaths that can tolerate latency. Operands are captured on a start/busy/done handshake. Results are held stable in output registers until the next operation completes.

## Interface
- `WIDTH`, default 4: operand and result width in bits; legal values are WIDTH ≥ 2.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `start`  in  1: request; sampled only while in IDLE.
- `a`  in  WIDTH: minuend; captured on an accepted start.
- `b`  in  WIDTH: subtrahend; captured on an accepted start.
- `bin`  in  1: borrow-in; captured on an accepted start.
- `busy`  out  1: high whenever state ≠ IDLE.
- `done`  out  1: one-cycle pulse; results are valid and newly updated.
- `diff`  out  WIDTH: registered difference, `(a - b - bin) mod 2^WIDTH`.
- `bout`  out  1: registered borrow-out; 1 iff unsigned `a < b + bin`.
- `ovf`  out  1: registered two's-complement overflow flag.

## Operation
- States:
  - IDLE: waiting for start.
  - SHIFT: WIDTH bit-cycles.
  - DONE: one cycle.
- IDLE → SHIFT when `start`=1 at a rising edge. On that edge:
  - capture `a` and `b` into internal shift registers;
  - capture `borrow` ← `bin`, bit counter ← 0;
  - latch `a[WIDTH-1]` and `b[WIDTH-1]` for the overflow check.
- SHIFT, each edge, with `x` = LSB of the a-shift-register and `y` = LSB of the b-shift-register:
  - `d = x ^ y ^ borrow`;
  - `borrow ← (~x & y) | (~(x ^ y) & borrow)`;
  - `d` enters the result shift register at the MSB and shifts right; both operand registers shift right;
  - counter increments.
- SHIFT → DONE on the edge that processes bit WIDTH-1 (counter == WIDTH-1). On that same edge:
  - `diff` ← full result, `bout` ← final borrow;
  - `ovf` ← (a_msb ≠ b_msb) & (result_msb ≠ a_msb).
- DONE → IDLE unconditionally on the next edge.
- `start` is ignored in SHIFT and DONE. Captured operands are unaffected by input changes after capture.
- `diff`, `bout` and `ovf` change only on the SHIFT→DONE edge. They hold their previous values throughout IDLE and SHIFT.
- The counter is ⌈log2(WIDTH)⌉ bits wide and never wraps past WIDTH-1 inside SHIFT.

## Timing
- Reset (`rst_n`=0, any time, asynchronous):
  - state → IDLE;
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0;
  - all internal registers → 0.
- Reset mid-operation aborts the operation. No `done` pulse is produced, and outputs return to 0.
- Release of `rst_n` is synchronous to `clk` in the surrounding system. The first start is accepted on the first rising edge with `rst_n`=1.
- Let E0 be the edge on which start is accepted:
  - `busy` rises after E0;
  - bit-cycles occur on E1..E(WIDTH);
  - `done`=1 and new results are visible after E(WIDTH), for exactly one cycle;
  - `busy` and `done` fall after E(WIDTH+1).
- Latency from start edge to `done`: WIDTH edges. Throughput: one operation per WIDTH+2 cycles.
- Back-to-back operation: `start` held high continuously is accepted again on the first edge after returning to IDLE, i.e. E(WIDTH+2).
- `done`, `busy`, `diff`, `bout` and `ovf` are all driven directly from registers, with no combinational path from inputs.

## Test plan
- Reset: assert `rst_n`=0 mid-clock with no edge → `busy`, `done`, `diff`, `bout` and `ovf` all read 0 immediately.
- Basic, WIDTH=4, a=0101, b=0010, bin=0 → `diff`=0011, `bout`=0, `ovf`=0. `done` high exactly one cycle, after the 4th edge following the start edge.
- Borrow and overflow cases, WIDTH=4:
  - 0000 − 0001, bin=0 → 1111, `bout`=1, `ovf`=0;
  - 1000 − 0001, bin=0 → 0111, `bout`=0, `ovf`=1;
  - 0111 − 1111, bin=0 → 1000, `bout`=1, `ovf`=1.
- Borrow-in: 1111 − 1111, bin=1 → `diff`=1111, `bout`=1, `ovf`=0. Also 0000 − 0000, bin=1 → 1111, `bout`=1, `ovf`=0.
- Handshake robustness:
  - pulse `start` with new operands during SHIFT and during DONE → ignored; result matches the first operands only;
  - change `a`/`b` mid-operation → no effect on the result;
  - `start` held high → operations at a period of 6 cycles, results correct for the operand values sampled at each accept edge.
- Reset mid-operation: assert `rst_n`=0 after E2 of a=1010, b=0101 → no `done` pulse, outputs 0. After release, a fresh 1010 − 0101 yields 0101, `bout`=0, `ovf`=1.
